// File: rtl/wb_uart_mc.sv
// wb_uart_mc: NUM_CH x 8N1 UART behind a Wishbone classic slave. Ack 1 cycle after request; TX writes to a full FIFO drop and flag TXOVF.
// Optional UART_LOOPBACK_EN builds a per-channel internal TX->RX loopback selected by CTRL.LOOP.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // count never exceeds DEPTH, a power of two, so its MSB alone means full
  assign out_vld = (count != '0);
  assign do_pop  = out_vld & out_rdy;
  assign in_rdy  = ~count[AW] | do_pop;
  assign do_push = in_vld & in_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end
endmodule

module wb_uart_mc #(
  parameter int          NUM_CH      = 2,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_CH-1:0] uart_rx_i,
  output logic [NUM_CH-1:0] uart_tx_o,
  output logic [NUM_CH-1:0] irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        req, ch_ok;
  logic [2:0]  ch;
  logic [1:0]  rsel;
  logic [31:0] rdata;
  logic [31:0] ch_rdata [NUM_CH];
  logic        unused_ok;

  // the ack cycle itself never starts a new access
  assign req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign ch    = wbs_adr_i[6:4];
  assign rsel  = wbs_adr_i[3:2];
  assign ch_ok = ~wbs_adr_i[7] & (int'(ch) < NUM_CH);
  assign unused_ok = &{1'b0, wbs_dat_i[31:19], wbs_adr_i[1:0], wbs_sel_i[3]};

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ok && ch == 3'(i)) rdata = ch_rdata[i];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic            hit, wr_data, rd_data, wr_stat, ctrl_we;
    logic [15:0]     div_q, div_eff;
    logic [2:0]      ie_q;
    logic            loop_q, rx_src, tx_q, irq_q;
    logic            rxovr_q, ferr_q, txovf_q;
    logic            tx_in_rdy, tx_ne, tx_pop, tx_busy, tx_end, tx_line;
    logic [7:0]      tx_head, tx_sh;
    logic [CW-1:0]   tx_cnt_f;
    logic [15:0]     tx_cnt, tx_div;
    logic [2:0]      tx_bit;
    tx_state_t       tx_st, tx_nxt;
    logic            rx_in_rdy, rx_ne, rx_s, rx_prev, rx_fall, rx_smp, stop_ok;
    logic [1:0]      rx_sync;
    logic [7:0]      rx_head, rx_sh;
    logic [CW-1:0]   rx_cnt_f;
    logic [15:0]     rx_cnt, rx_div;
    logic [2:0]      rx_bit;
    rx_state_t       rx_st, rx_nxt;
    logic [31:0]     data_rd, stat_rd, ctrl_rd;

    assign hit     = req & ch_ok & (ch == 3'(c));
    assign wr_data = hit & wbs_we_i & (rsel == 2'd0) & wbs_sel_i[0];
    assign rd_data = hit & ~wbs_we_i & (rsel == 2'd0);
    assign wr_stat = hit & wbs_we_i & (rsel == 2'd1) & wbs_sel_i[0];
    assign ctrl_we = hit & wbs_we_i & (rsel == 2'd2);
    assign div_eff = (div_q < 16'd4) ? 16'd4 : div_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        div_q <= DEFAULT_DIV;
        ie_q  <= '0;
      end else if (ctrl_we) begin
        if (wbs_sel_i[0]) div_q[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) div_q[15:8] <= wbs_dat_i[15:8];
        if (wbs_sel_i[2]) ie_q        <= wbs_dat_i[18:16];
      end
    end

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)                  loop_q <= 1'b0;
      else if (ctrl_we && wbs_sel_i[2]) loop_q <= wbs_dat_i[19];
    end
    assign rx_src       = loop_q ? tx_q : uart_rx_i[c];
    assign uart_tx_o[c] = tx_q | loop_q;
`else
    assign loop_q       = 1'b0;
    assign rx_src       = uart_rx_i[c];
    assign uart_tx_o[c] = tx_q;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(wb_clk_i), .rst_n(wb_rst_n_i),
      .in_vld(wr_data), .in_rdy(tx_in_rdy), .in_dat(wbs_dat_i[7:0]),
      .out_vld(tx_ne), .out_rdy(tx_pop), .out_dat(tx_head), .count(tx_cnt_f)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(wb_clk_i), .rst_n(wb_rst_n_i),
      .in_vld(stop_ok), .in_rdy(rx_in_rdy), .in_dat(rx_sh),
      .out_vld(rx_ne), .out_rdy(rd_data), .out_dat(rx_head), .count(rx_cnt_f)
    );

    // ---------------- transmitter ----------------
    assign tx_busy = (tx_st != TX_IDLE);
    assign tx_end  = (tx_cnt == tx_div - 16'd1);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) tx_st <= TX_IDLE;
      else             tx_st <= tx_nxt;
    end

    // STOP reloads straight into START when more data is queued
    always_comb begin
      tx_nxt  = tx_st;
      tx_pop  = 1'b0;
      tx_line = 1'b1;
      case (tx_st)
        TX_IDLE:  if (tx_ne) begin tx_pop = 1'b1; tx_nxt = TX_START; end
        TX_START: begin tx_line = 1'b0; if (tx_end) tx_nxt = TX_DATA; end
        TX_DATA:  begin tx_line = tx_sh[0]; if (tx_end && tx_bit == 3'd7) tx_nxt = TX_STOP; end
        TX_STOP:  if (tx_end) begin
                    if (tx_ne) begin tx_pop = 1'b1; tx_nxt = TX_START; end
                    else tx_nxt = TX_IDLE;
                  end
        default:  tx_nxt = TX_IDLE;
      endcase
    end

    // divisor is latched per frame so CTRL writes never disturb a frame in flight
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        tx_sh  <= '0;
        tx_cnt <= '0;
        tx_div <= DEFAULT_DIV;
        tx_bit <= '0;
        tx_q   <= 1'b1;
      end else begin
        tx_q <= tx_line;
        if (tx_pop) begin
          tx_sh  <= tx_head;
          tx_cnt <= '0;
          tx_div <= div_eff;
          tx_bit <= '0;
        end else if (tx_busy) begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_st == TX_DATA) begin
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      end
    end

    // ---------------- receiver ----------------
    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;
    assign rx_smp  = (rx_st == RX_START) ? (rx_cnt == {1'b0, rx_div[15:1]})
                                         : (rx_cnt == rx_div - 16'd1);
    assign stop_ok = (rx_st == RX_STOP) & rx_smp & rx_s;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) rx_st <= RX_IDLE;
      else             rx_st <= rx_nxt;
    end

    always_comb begin
      rx_nxt = rx_st;
      case (rx_st)
        RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
        RX_START: if (rx_smp) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rx_smp && rx_bit == 3'd7) rx_nxt = RX_STOP;
        RX_STOP:  if (rx_smp) rx_nxt = RX_IDLE;
        default:  rx_nxt = RX_IDLE;
      endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        rx_sync <= 2'b11;
        rx_prev <= 1'b1;
        rx_sh   <= '0;
        rx_cnt  <= '0;
        rx_div  <= DEFAULT_DIV;
        rx_bit  <= '0;
      end else begin
        rx_sync <= {rx_sync[0], rx_src};
        rx_prev <= rx_s;
        if (rx_st == RX_IDLE) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_fall) rx_div <= div_eff;
        end else if (rx_smp) begin
          rx_cnt <= '0;
          if (rx_st == RX_DATA) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
          end
        end else begin
          rx_cnt <= rx_cnt + 16'd1;
        end
      end
    end

    // ---------------- sticky flags, irq, readback ----------------
    // a hardware set in the same cycle as a clear wins
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        rxovr_q <= 1'b0;
        ferr_q  <= 1'b0;
        txovf_q <= 1'b0;
        irq_q   <= 1'b0;
      end else begin
        rxovr_q <= (rxovr_q & ~(wr_stat & wbs_dat_i[4])) | (stop_ok & ~rx_in_rdy);
        ferr_q  <= (ferr_q  & ~(wr_stat & wbs_dat_i[5])) | ((rx_st == RX_STOP) & rx_smp & ~rx_s);
        txovf_q <= (txovf_q & ~(wr_stat & wbs_dat_i[6])) | (wr_data & ~tx_in_rdy);
        irq_q   <= (ie_q[0] & rx_ne) | (ie_q[1] & ~tx_ne & ~tx_busy) |
                   (ie_q[2] & (rxovr_q | ferr_q | txovf_q));
      end
    end
    assign irq_o[c] = irq_q;

    assign data_rd = rx_ne ? {23'b0, 1'b1, rx_head} : '0;
    assign stat_rd = {16'b0, 8'(rx_cnt_f), 1'b0, txovf_q, ferr_q, rxovr_q,
                      tx_busy, (tx_cnt_f == '0), tx_cnt_f[CW-1], rx_ne};
    assign ctrl_rd = {12'b0, loop_q, ie_q, div_q};
    assign ch_rdata[c] = (rsel == 2'd0) ? data_rd :
                         (rsel == 2'd1) ? stat_rd :
                         (rsel == 2'd2) ? ctrl_rd : '0;
  end
endmodule

// File: tb/tb_wb_uart_mc.sv
// Directed bench for wb_uart_mc: register vector table plus TX/RX/IRQ/loopback/reset sequences.
// Build with +define+UART_LOOPBACK_EN to exercise the loopback section.
module tb_wb_uart_mc;
  localparam logic [31:0] B = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic [1:0]  rx_line;
  logic [1:0]  tx_line;
  logic [1:0]  irq;

  int n_vec = 0;
  int n_err = 0;

  wb_uart_mc #(.NUM_CH(2), .FIFO_DEPTH(4), .BASE_ADDR(B), .DEFAULT_DIV(16'd434)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .uart_rx_i(rx_line), .uart_tx_o(tx_line), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q, output logic ok);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    ok = 1'b0; q = '0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1'b1; q = dat_o; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    logic ok;
    wb_xfer(a, 1'b1, d, s, q, ok);
    chk({nm, "_ack"}, 32'(ok), 32'd1);
  endtask

  task automatic wb_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q;
    logic ok;
    wb_xfer(a, 1'b0, '0, 4'hF, q, ok);
    chk({nm, "_ack"}, 32'(ok), 32'd1);
    chk(nm, q, exp);
  endtask

  task automatic send_rx(input int c, input logic [7:0] b, input logic stop_bit, input int bl);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(negedge clk); rx_line[c] = f[j];
      repeat (bl - 1) @(negedge clk);
    end
    @(negedge clk); rx_line[c] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  logic tx_log [300];

  initial begin
    logic [31:0] q;
    logic        ok;
    logic [9:0]  got;
    int          t0;
    int          lows;
    logic [9:0]  frm;

    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; rx_line = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_tx", 32'(tx_line), 32'd3);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // ---- register vector table ----
    vt[0]  = '{1'b0, B + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0000_01B2};
    vt[1]  = '{1'b0, B + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0000_0004};
    vt[2]  = '{1'b0, B + 32'h00, 32'h0, 4'hF, 1'b1, 32'h0000_0000};
    vt[3]  = '{1'b0, B + 32'h18, 32'h0, 4'hF, 1'b1, 32'h0000_01B2};
    vt[4]  = '{1'b1, B + 32'h08, 32'hFFFF_FFFF, 4'b0100, 1'b1, 32'h0};
`ifdef UART_LOOPBACK_EN
    vt[5]  = '{1'b0, B + 32'h08, 32'h0, 4'hF, 1'b1, 32'h000F_01B2};
`else
    vt[5]  = '{1'b0, B + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0007_01B2};
`endif
    vt[6]  = '{1'b1, B + 32'h08, 32'h0000_0004, 4'hF, 1'b1, 32'h0};
    vt[7]  = '{1'b0, B + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0000_0004};
    vt[8]  = '{1'b1, B + 32'h08, 32'hAAAA_AA09, 4'b0001, 1'b1, 32'h0};
    vt[9]  = '{1'b0, B + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0000_0009};
    vt[10] = '{1'b1, B + 32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vt[11] = '{1'b0, B + 32'h0C, 32'h0, 4'hF, 1'b1, 32'h0};
    vt[12] = '{1'b1, B + 32'h70, 32'h0000_0055, 4'hF, 1'b1, 32'h0};
    vt[13] = '{1'b0, B + 32'h70, 32'h0, 4'hF, 1'b1, 32'h0};
    vt[14] = '{1'b0, B + 32'h80, 32'h0, 4'hF, 1'b1, 32'h0};
    vt[15] = '{1'b0, B + 32'h100, 32'h0, 4'hF, 1'b0, 32'h0};
    vt[16] = '{1'b0, 32'h2000_0008, 32'h0, 4'hF, 1'b0, 32'h0};
    vt[17] = '{1'b1, B + 32'h08, 32'h0000_0004, 4'b0011, 1'b1, 32'h0};
    vt[18] = '{1'b1, B + 32'h18, 32'h0000_0008, 4'b0011, 1'b1, 32'h0};
    vt[19] = '{1'b0, B + 32'h18, 32'h0, 4'hF, 1'b1, 32'h0000_0008};
    vt[20] = '{1'b0, B + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0000_0004};

    for (int i = 0; i < 21; i++) begin
      wb_xfer(vt[i].adr, vt[i].we, vt[i].dat, vt[i].sel, q, ok);
      chk($sformatf("vec%0d_ack", i), 32'(ok), 32'(vt[i].exp_ack));
      if (!vt[i].we && vt[i].exp_ack) chk($sformatf("vec%0d_dat", i), q, vt[i].exp_dat);
    end

    // ---- single frame 0x55 on ch0, div 4 ----
    frm = {1'b1, 8'h55, 1'b0};
    wb_wr("a_push", B, 32'h55, 4'b0001);
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("a_tx_pre", 32'(tx_line[0]), 32'd1);
      else        chk($sformatf("a_tx%0d", k), 32'(tx_line[0]), 32'(frm[(k - 2) / 4]));
    end
    repeat (2) @(posedge clk);
    wb_rd("a_status", B + 32'h04, 32'h0000_0004);

    // ---- TX overflow and back-to-back frames ----
    fork
      begin
        logic [31:0] fq;
        logic        fok;
        for (int i = 0; i < 6; i++) begin
          wb_xfer(B, 1'b1, 32'(i + 1), 4'b0001, fq, fok);
          chk($sformatf("b_push%0d_ack", i), 32'(fok), 32'd1);
        end
      end
      begin
        for (int k = 0; k < 300; k++) begin
          @(posedge clk); #1;
          tx_log[k] = tx_line[0];
        end
      end
    join
    t0 = -1;
    for (int k = 0; k < 300; k++) if (t0 < 0 && tx_log[k] == 1'b0) t0 = k;
    chk("b_start_seen", 32'(t0 >= 0 && t0 < 90), 32'd1);
    if (t0 >= 0 && t0 < 90) begin
      for (int f = 0; f < 5; f++) begin
        for (int j = 0; j < 10; j++) got[j] = tx_log[t0 + 40 * f + 4 * j + 2];
        chk($sformatf("b_frame%0d", f), 32'(got), 32'({1'b1, 8'(f + 1), 1'b0}));
      end
      chk("b_idle_after", 32'(tx_log[t0 + 202]), 32'd1);
    end
    wb_rd("b_status", B + 32'h04, 32'h0000_0044);
    wb_wr("b_clr", B + 32'h04, 32'h0000_0040, 4'b0001);
    wb_rd("b_status_clr", B + 32'h04, 32'h0000_0004);

    // ---- RX on ch1, div 8 ----
    send_rx(1, 8'hA3, 1'b1, 8);
    wb_rd("c_status", B + 32'h14, 32'h0000_0105);
    wb_rd("c_data", B + 32'h10, 32'h0000_01A3);
    wb_rd("c_data_empty", B + 32'h10, 32'h0);
    send_rx(1, 8'h5A, 1'b0, 8);
    wb_rd("c_ferr", B + 32'h14, 32'h0000_0024);
    wb_wr("c_ferr_clr", B + 32'h14, 32'h0000_0020, 4'b0001);
    wb_rd("c_ferr_gone", B + 32'h14, 32'h0000_0004);
    for (int i = 0; i < 5; i++) send_rx(1, 8'(8'h10 + i), 1'b1, 8);
    wb_rd("c_ovr", B + 32'h14, 32'h0000_0415);
    for (int i = 0; i < 4; i++)
      wb_rd($sformatf("c_ovr_data%0d", i), B + 32'h10, 32'h0000_0110 + 32'(i));
    wb_rd("c_ovr_drained", B + 32'h14, 32'h0000_0014);
    wb_wr("c_ovr_clr", B + 32'h14, 32'h0000_0010, 4'b0001);
    wb_rd("c_ovr_gone", B + 32'h14, 32'h0000_0004);

    // ---- glitch rejection at div 16 ----
    wb_wr("d_div", B + 32'h18, 32'h0000_0010, 4'b0011);
    @(negedge clk); rx_line[1] = 1'b0;
    repeat (2) @(negedge clk);
    rx_line[1] = 1'b1;
    repeat (40) @(negedge clk);
    wb_rd("d_status", B + 32'h14, 32'h0000_0004);

    // ---- TX-empty interrupt ----
    wb_wr("e_ie", B + 32'h08, 32'h0002_0004, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("e_irq_idle", 32'(irq), 32'd1);
    wb_wr("e_push", B, 32'h0, 4'b0001);
    repeat (20) @(posedge clk);
    #1;
    chk("e_irq_mid", 32'(irq[0]), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      if (irq[0]) ok = 1'b1;
    end
    chk("e_irq_after", 32'(ok), 32'd1);
    chk("e_irq_ch1", 32'(irq[1]), 32'd0);
    wb_wr("e_ie_off", B + 32'h08, 32'h0000_0004, 4'hF);

`ifdef UART_LOOPBACK_EN
    // ---- internal loopback on ch0 ----
    wb_wr("f_loop", B + 32'h08, 32'h0008_0004, 4'hF);
    lows = 0;
    fork
      wb_wr("f_push", B, 32'h0000_00C3, 4'b0001);
      begin
        for (int k = 0; k < 90; k++) begin
          @(posedge clk); #1;
          if (!tx_line[0]) lows++;
        end
      end
    join
    chk("f_tx_high", 32'(lows), 32'd0);
    wb_rd("f_data", B, 32'h0000_01C3);
    wb_wr("f_loop_off", B + 32'h08, 32'h0000_0004, 4'hF);
`endif

    // ---- reset mid-frame ----
    wb_wr("g_push0", B, 32'h0, 4'b0001);
    wb_wr("g_push1", B, 32'h0, 4'b0001);
    repeat (8) @(posedge clk);
    #1;
    chk("g_tx_low", 32'(tx_line[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("g_tx_async", 32'(tx_line), 32'd3);
    @(negedge clk); rst_n = 1'b1;
    wb_rd("g_status", B + 32'h04, 32'h0000_0004);
    wb_rd("g_ctrl", B + 32'h08, 32'h0000_01B2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
